// File: rtl/aes_round_ctrl.sv
// Round sequencer for the iterative AES-128 core: LOAD, NR-1 mixing rounds, FINAL, then result hold.
// Optional decrypt support (descending round index, rcon forced to zero) under AES_ROUND_CTRL_DECRYPT_EN.
module aes_round_ctrl #(
  parameter int NR = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
`ifdef AES_ROUND_CTRL_DECRYPT_EN
  input  logic       decrypt,
`endif
  output logic       ready,
  output logic       busy,
  output logic       key_load,
  output logic       addkey_en,
  output logic       round_en,
  output logic       mix_en,
  output logic [3:0] round_idx,
  output logic [7:0] rcon,
  output logic       out_valid,
  input  logic       out_ready
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_ROUND = 3'd2;
  localparam logic [2:0] S_FINAL = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [3:0] NR_IDX   = 4'(NR);
  localparam logic [3:0] LAST_ENC = 4'(NR - 1);

  logic [2:0] state_reg, state_next;
  logic [3:0] round_idx_reg, round_idx_next;
  logic [7:0] rcon_reg, rcon_next;
  logic       dec_reg, dec_next;
  logic       start_dec;

`ifdef AES_ROUND_CTRL_DECRYPT_EN
  assign start_dec = decrypt;
`else
  assign start_dec = 1'b0;
`endif

  function automatic logic [7:0] xtime(input logic [7:0] v);
    xtime = {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
  endfunction

  always_comb begin
    state_next     = state_reg;
    round_idx_next = round_idx_reg;
    rcon_next      = rcon_reg;
    dec_next       = dec_reg;
    case (state_reg)
      S_IDLE: begin
        round_idx_next = 4'd0;
        rcon_next      = 8'h00;
        if (start) begin
          state_next     = S_LOAD;
          dec_next       = start_dec;
          round_idx_next = start_dec ? NR_IDX : 4'd0;
        end
      end
      S_LOAD: begin
        state_next     = S_ROUND;
        round_idx_next = dec_reg ? LAST_ENC : 4'd1;
        rcon_next      = dec_reg ? 8'h00 : 8'h01;
      end
      S_ROUND: begin
        round_idx_next = dec_reg ? round_idx_reg - 4'd1 : round_idx_reg + 4'd1;
        rcon_next      = dec_reg ? 8'h00 : xtime(rcon_reg);
        if (round_idx_reg == (dec_reg ? 4'd1 : LAST_ENC))
          state_next = S_FINAL;
      end
      S_FINAL: begin
        state_next = S_DONE;
      end
      S_DONE: begin
        // Result, index and rcon stay frozen until the consumer takes the block.
        if (out_ready) begin
          state_next     = S_IDLE;
          round_idx_next = 4'd0;
          rcon_next      = 8'h00;
        end
      end
      default: begin
        state_next     = S_IDLE;
        round_idx_next = 4'd0;
        rcon_next      = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= S_IDLE;
      round_idx_reg <= 4'd0;
      rcon_reg      <= 8'h00;
      dec_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      round_idx_reg <= round_idx_next;
      rcon_reg      <= rcon_next;
      dec_reg       <= dec_next;
    end
  end

  assign ready     = (state_reg == S_IDLE);
  assign busy      = (state_reg == S_LOAD) || (state_reg == S_ROUND) || (state_reg == S_FINAL);
  assign key_load  = (state_reg == S_LOAD);
  assign addkey_en = busy;
  assign round_en  = (state_reg == S_ROUND) || (state_reg == S_FINAL);
  assign mix_en    = (state_reg == S_ROUND);
  assign out_valid = (state_reg == S_DONE);
  assign round_idx = round_idx_reg;
  assign rcon      = rcon_reg;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: NR=10 and NR=14 instances, backpressure, mid-block reset,
// and the decrypt sequence when AES_ROUND_CTRL_DECRYPT_EN is defined.
module tb_aes_round_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       start10, out_ready10, decrypt10;
  logic       start14, out_ready14, decrypt14;
  logic       ready10, busy10, key_load10, addkey10, round_en10, mix10, out_valid10;
  logic       ready14, busy14, key_load14, addkey14, round_en14, mix14, out_valid14;
  logic [3:0] idx10, idx14;
  logic [7:0] rcon10, rcon14;

  aes_round_ctrl #(.NR(10)) dut10 (
    .clk(clk), .reset(reset), .start(start10),
`ifdef AES_ROUND_CTRL_DECRYPT_EN
    .decrypt(decrypt10),
`endif
    .ready(ready10), .busy(busy10), .key_load(key_load10), .addkey_en(addkey10),
    .round_en(round_en10), .mix_en(mix10), .round_idx(idx10), .rcon(rcon10),
    .out_valid(out_valid10), .out_ready(out_ready10)
  );

  aes_round_ctrl #(.NR(14)) dut14 (
    .clk(clk), .reset(reset), .start(start14),
`ifdef AES_ROUND_CTRL_DECRYPT_EN
    .decrypt(decrypt14),
`endif
    .ready(ready14), .busy(busy14), .key_load(key_load14), .addkey_en(addkey14),
    .round_en(round_en14), .mix_en(mix14), .round_idx(idx14), .rcon(rcon14),
    .out_valid(out_valid14), .out_ready(out_ready14)
  );

  // Flag order: ready, busy, key_load, addkey_en, round_en, mix_en, out_valid
  localparam logic [6:0] F_IDLE  = 7'b1000000;
  localparam logic [6:0] F_LOAD  = 7'b0111000;
  localparam logic [6:0] F_ROUND = 7'b0101110;
  localparam logic [6:0] F_FINAL = 7'b0101100;
  localparam logic [6:0] F_DONE  = 7'b0000001;

  logic [6:0] flags10, flags14;
  assign flags10 = {ready10, busy10, key_load10, addkey10, round_en10, mix10, out_valid10};
  assign flags14 = {ready14, busy14, key_load14, addkey14, round_en14, mix14, out_valid14};

  logic [7:0] rcon_tab [0:15];
  int assert_count = 0;
  int fail_count   = 0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assert_count++;
    if (got !== exp) begin
      fail_count++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_state(input bit sel, input string tag, input logic [6:0] f,
                             input logic [3:0] idx, input logic [7:0] rc);
    check_value({tag, "_flags"}, 32'(sel ? flags14 : flags10), 32'(f));
    check_value({tag, "_idx"},   32'(sel ? idx14 : idx10),     32'(idx));
    check_value({tag, "_rcon"},  32'(sel ? rcon14 : rcon10),   32'(rc));
  endtask

  // Starts a block on the selected instance and checks every cycle up to the first DONE cycle.
  task automatic run_block(input bit sel, input bit dec, input int nr);
    logic [3:0] fidx;
    logic [7:0] frc;
    if (sel) begin start14 = 1'b1; decrypt14 = dec; end
    else begin start10 = 1'b1; decrypt10 = dec; end
    @(negedge clk);
    start10 = 1'b0; start14 = 1'b0;
    check_state(sel, "load", F_LOAD, dec ? 4'(nr) : 4'd0, 8'h00);
    for (int r = 1; r < nr; r++) begin
      @(negedge clk);
      check_state(sel, $sformatf("round%0d", r), F_ROUND,
                  dec ? 4'(nr - r) : 4'(r), dec ? 8'h00 : rcon_tab[r]);
    end
    fidx = dec ? 4'd0 : 4'(nr);
    frc  = dec ? 8'h00 : rcon_tab[nr];
    @(negedge clk);
    check_state(sel, "final", F_FINAL, fidx, frc);
    @(negedge clk);
    check_state(sel, "done", F_DONE, fidx, frc);
    $display("block nr=%0d dec=%0d reached DONE at %0t", nr, dec, $time);
  endtask

  initial begin
    rcon_tab[0]  = 8'h00; rcon_tab[1]  = 8'h01; rcon_tab[2]  = 8'h02; rcon_tab[3]  = 8'h04;
    rcon_tab[4]  = 8'h08; rcon_tab[5]  = 8'h10; rcon_tab[6]  = 8'h20; rcon_tab[7]  = 8'h40;
    rcon_tab[8]  = 8'h80; rcon_tab[9]  = 8'h1b; rcon_tab[10] = 8'h36; rcon_tab[11] = 8'h6c;
    rcon_tab[12] = 8'hd8; rcon_tab[13] = 8'hab; rcon_tab[14] = 8'h4d; rcon_tab[15] = 8'h9a;

    reset = 1'b0;
    start10 = 1'b0; out_ready10 = 1'b1; decrypt10 = 1'b0;
    start14 = 1'b0; out_ready14 = 1'b1; decrypt14 = 1'b0;

    // Reset held, then idle with start low
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_state(1'b0, "rst10", F_IDLE, 4'd0, 8'h00);
      check_state(1'b1, "rst14", F_IDLE, 4'd0, 8'h00);
    end
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_state(1'b0, "idle10", F_IDLE, 4'd0, 8'h00);
    end

    // Nominal NR=10 with out_ready high: one DONE cycle, then IDLE
    run_block(1'b0, 1'b0, 10);
    @(negedge clk);
    check_state(1'b0, "post_nominal", F_IDLE, 4'd0, 8'h00);

    // Backpressure with a start pulse inside DONE
    out_ready10 = 1'b0;
    run_block(1'b0, 1'b0, 10);
    for (int i = 0; i < 7; i++) begin
      start10 = (i == 2);
      @(negedge clk);
      check_state(1'b0, $sformatf("hold%0d", i), F_DONE, 4'd10, 8'h36);
    end
    start10 = 1'b0;
    out_ready10 = 1'b1;
    @(negedge clk);
    check_state(1'b0, "release", F_IDLE, 4'd0, 8'h00);
    run_block(1'b0, 1'b0, 10);
    @(negedge clk);
    check_state(1'b0, "second_block", F_IDLE, 4'd0, 8'h00);

    // Reset in the middle of a block at round_idx=5
    start10 = 1'b1;
    @(negedge clk);
    start10 = 1'b0;
    for (int i = 0; i < 5; i++) @(negedge clk);
    check_state(1'b0, "pre_reset", F_ROUND, 4'd5, 8'h10);
    reset = 1'b0;
    #1;
    check_state(1'b0, "mid_reset", F_IDLE, 4'd0, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_state(1'b0, "after_reset", F_IDLE, 4'd0, 8'h00);
    run_block(1'b0, 1'b0, 10);
    @(negedge clk);
    check_state(1'b0, "after_reset_blk", F_IDLE, 4'd0, 8'h00);

    // NR=14 instance
    run_block(1'b1, 1'b0, 14);
    @(negedge clk);
    check_state(1'b1, "post_nr14", F_IDLE, 4'd0, 8'h00);

`ifdef AES_ROUND_CTRL_DECRYPT_EN
    run_block(1'b0, 1'b1, 10);
    decrypt10 = 1'b0;
    @(negedge clk);
    check_state(1'b0, "post_decrypt", F_IDLE, 4'd0, 8'h00);
    run_block(1'b0, 1'b0, 10);
    @(negedge clk);
    check_state(1'b0, "enc_after_dec", F_IDLE, 4'd0, 8'h00);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
